// File: rtl/req_ack_arbiter.sv
// Round-robin arbiter sharing one four-phase req/ack server among NUM_CLI clients.
// Optional watchdog with error completion and DRAIN state: define ARB_TIMEOUT_EN.
module req_ack_arbiter #(
    parameter int NUM_CLI     = 4,
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CLI-1:0]    cli_req,
    input  logic [NUM_CLI*DW-1:0] cli_wdata,
    output logic [NUM_CLI-1:0]    cli_done,
    output logic                  cli_err,
    output logic [DW-1:0]         cli_rdata,
    output logic                  srv_req,
    output logic [DW-1:0]         srv_wdata,
    input  logic                  srv_ack,
    input  logic [DW-1:0]         srv_rdata
);

    localparam int PW = (NUM_CLI > 1) ? $clog2(NUM_CLI) : 1;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL, S_DRAIN} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_t;
`endif

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic [PW-1:0]          gnt_q, gnt_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]          srv_wdata_q, srv_wdata_d;
    logic [DW-1:0]          rdata_cap_q, rdata_cap_d;
    logic [DW-1:0]          cli_rdata_q, cli_rdata_d;
    logic [NUM_CLI-1:0]     cli_done_q, cli_done_d;
    logic                   srv_req_q, srv_req_d;
`ifdef ARB_TIMEOUT_EN
    logic                   cli_err_q, cli_err_d;
    logic [CW-1:0]          wd_q, wd_d;
    logic                   wd_hit;
`endif

    logic                   ack_s;
    logic [NUM_CLI-1:0]     elig;
    logic [NUM_CLI-1:0]     gnt_oh;
    logic [PW-1:0]          pick;
    logic [PW-1:0]          nxt_ptr;
    logic                   found;
    int                     j;

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    always_comb begin
        ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], srv_ack};
    end

    // Round-robin search from rr_ptr upward with wrap.
    always_comb begin
        elig  = cli_req & ~cli_done_q;
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int i = 0; i < NUM_CLI; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= NUM_CLI) j = j - NUM_CLI;
            if (!found && elig[j]) begin
                found = 1'b1;
                pick  = PW'(j);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CLI; i++) begin
            gnt_oh[i] = (gnt_q == PW'(i));
        end
        nxt_ptr = (gnt_q == PW'(NUM_CLI - 1)) ? '0 : gnt_q + PW'(1);
    end

`ifdef ARB_TIMEOUT_EN
    assign wd_hit = (wd_q == CW'(TIMEOUT_CYC - 1));
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        srv_wdata_d = srv_wdata_q;
        rdata_cap_d = rdata_cap_q;
        cli_rdata_d = cli_rdata_q;
        cli_done_d  = '0;
`ifdef ARB_TIMEOUT_EN
        cli_err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // A grant waits while the previous ack is still visible.
                if (found && !ack_s) begin
                    gnt_d       = pick;
                    srv_wdata_d = cli_wdata[pick*DW +: DW];
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_s) begin
                    rdata_cap_d = srv_rdata;
                    state_d     = S_REL;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wd_hit) begin
                    cli_done_d  = gnt_oh;
                    cli_err_d   = 1'b1;
                    cli_rdata_d = '0;
                    rr_ptr_d    = nxt_ptr;
                    state_d     = S_DRAIN;
                end
`endif
            end
            S_REL: begin
                if (!ack_s) begin
                    cli_done_d  = gnt_oh;
                    cli_rdata_d = rdata_cap_q;
                    rr_ptr_d    = nxt_ptr;
                    state_d     = S_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wd_hit) begin
                    cli_done_d  = gnt_oh;
                    cli_err_d   = 1'b1;
                    cli_rdata_d = '0;
                    rr_ptr_d    = nxt_ptr;
                    state_d     = S_DRAIN;
                end
`endif
            end
`ifdef ARB_TIMEOUT_EN
            S_DRAIN: begin
                if (!ack_s) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        srv_req_d = (state_d == S_REQ);
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog restarts on every state change and only counts in REQ/REL.
    always_comb begin
        wd_d = '0;
        if (state_d == state_q &&
            (state_q == S_REQ || state_q == S_REL)) begin
            wd_d = wd_q + CW'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ack_sync_q  <= '0;
            gnt_q       <= '0;
            rr_ptr_q    <= '0;
            srv_wdata_q <= '0;
            rdata_cap_q <= '0;
            cli_rdata_q <= '0;
            cli_done_q  <= '0;
            srv_req_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cli_err_q   <= 1'b0;
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ack_sync_q  <= ack_sync_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            srv_wdata_q <= srv_wdata_d;
            rdata_cap_q <= rdata_cap_d;
            cli_rdata_q <= cli_rdata_d;
            cli_done_q  <= cli_done_d;
            srv_req_q   <= srv_req_d;
`ifdef ARB_TIMEOUT_EN
            cli_err_q   <= cli_err_d;
            wd_q        <= wd_d;
`endif
        end
    end

    assign cli_done  = cli_done_q;
    assign cli_rdata = cli_rdata_q;
    assign srv_req   = srv_req_q;
    assign srv_wdata = srv_wdata_q;
`ifdef ARB_TIMEOUT_EN
    assign cli_err   = cli_err_q;
`else
    assign cli_err   = 1'b0;
`endif

endmodule

// File: tb/tb_req_ack_arbiter.sv
// Scoreboard bench for req_ack_arbiter: directed vectors, queued expectations,
// independent grant/done monitors; watchdog case only with ARB_TIMEOUT_EN.
module tb_req_ack_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        cli_req;
    logic [N*DW-1:0]     cli_wdata;
    logic [N-1:0]        cli_done;
    logic                cli_err;
    logic [DW-1:0]       cli_rdata;
    logic                srv_req;
    logic [DW-1:0]       srv_wdata;
    logic                srv_ack;
    logic [DW-1:0]       srv_rdata;

    req_ack_arbiter #(
        .NUM_CLI(N), .DW(DW), .SYNC_STAGES(2), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cli_req(cli_req), .cli_wdata(cli_wdata),
        .cli_done(cli_done), .cli_err(cli_err), .cli_rdata(cli_rdata),
        .srv_req(srv_req), .srv_wdata(srv_wdata),
        .srv_ack(srv_ack), .srv_rdata(srv_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  done;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          done_q[$];
    logic [DW-1:0] gnt_q[$];
    int            checks = 0;
    int            passed = 0;
    int            done_cnt = 0;
    int            rem[N];
    int            dly = 3;
    int            hold = 1;
    logic [DW-1:0] key = '0;
    bit            auto_srv = 1'b1;
    logic          req_prev = 1'b0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] wd(int c);
        return cli_wdata[c*DW +: DW];
    endfunction

    task automatic push(int c);
        exp_t e;
        e.done  = N'(1) << c;
        e.rdata = wd(c) ^ key;
        e.err   = 1'b0;
        gnt_q.push_back(wd(c));
        done_q.push_back(e);
    endtask

    task automatic issue(int c, int n);
        rem[c]     = n;
        cli_req[c] = 1'b1;
    endtask

    task automatic wait_done(int target, int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_done", 64'(done_cnt >= target), 64'd1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Done and grant monitors
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cli_done != '0) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    check("stray_done", 64'(cli_done), 64'd0);
                end else begin
                    e = done_q.pop_front();
                    check("done_vec", 64'(cli_done), 64'(e.done));
                    check("done_rdata", 64'(cli_rdata), 64'(e.rdata));
                    check("done_err", 64'(cli_err), 64'(e.err));
                end
            end
            if (srv_req && !req_prev) begin
                if (gnt_q.size() == 0)
                    check("stray_grant", 64'(srv_req), 64'd0);
                else
                    check("grant_wdata", 64'(srv_wdata), 64'(gnt_q.pop_front()));
            end
            req_prev = srv_req;
        end
    end

    // Clients drop their request after the last expected completion
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (cli_done[i] && rem[i] > 0) begin
                    rem[i]--;
                    if (rem[i] == 0) cli_req[i] = 1'b0;
                end
            end
        end
    end

    // Server model
    initial begin
        forever begin
            @(posedge clk);
            if (auto_srv && srv_req) begin
                repeat (dly) @(posedge clk);
                if (auto_srv && srv_req) begin
                    #1;
                    srv_rdata = srv_wdata ^ key;
                    srv_ack   = 1'b1;
                    while (srv_req) @(posedge clk);
                    repeat (hold) @(posedge clk);
                    #1;
                    srv_ack = 1'b0;
                end
            end
        end
    end

    initial begin
        int k;
        int bad;
        logic [DW-1:0] w;
        exp_t e;
        rst       = 1'b1;
        cli_req   = '0;
        cli_wdata = '0;
        srv_ack   = 1'b0;
        srv_rdata = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_srv_req", 64'(srv_req), 64'd0);
        check("rst_srv_wdata", 64'(srv_wdata), 64'd0);
        check("rst_cli_done", 64'(cli_done), 64'd0);
        check("rst_cli_err", 64'(cli_err), 64'd0);
        check("rst_cli_rdata", 64'(cli_rdata), 64'd0);

        // T1 single
        cli_wdata[0 +: DW] = 32'h0000_1234;
        push(0);
        issue(0, 1);
        wait_done(1, 100);
        repeat (5) @(negedge clk);
        check("rdata_held", 64'(cli_rdata), 64'h1234);

        // T2 round-robin 0,1,2,3,0
        apply_reset();
        key = 32'hA5A5_0000;
        for (int i = 0; i < N; i++) cli_wdata[i*DW +: DW] = DW'(i);
        push(0); push(1); push(2); push(3); push(0);
        rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
        cli_req = 4'b1111;
        wait_done(6, 300);

        // T3 wrap/skip from rr_ptr=3
        for (int i = 0; i < N; i++)
            cli_wdata[i*DW +: DW] = 32'hC0DE_0000 | DW'(i);
        push(2);
        issue(2, 1);
        wait_done(7, 100);
        push(0); push(2);
        issue(0, 1); issue(2, 1);
        wait_done(9, 200);

        // T4a long ack hold, srv_wdata stable
        hold = 20;
        push(1);
        issue(1, 1);
        k = 0;
        while (!srv_req && k < 20) begin @(negedge clk); k++; end
        w = srv_wdata;
        bad = 0;
        k = 0;
        while (done_cnt < 10 && k < 200) begin
            @(negedge clk);
            if (cli_done == '0 && srv_wdata !== w) bad++;
            k++;
        end
        check("wdata_stable", 64'(bad), 64'd0);
        check("t4a_done", 64'(done_cnt), 64'd10);
        hold = 1;

        // T4b ack high in IDLE blocks the grant
        repeat (3) @(negedge clk);
        auto_srv = 1'b0;
        srv_ack  = 1'b1;
        repeat (4) @(negedge clk);
        w = srv_wdata;
        push(1);
        issue(1, 1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (srv_req || srv_wdata !== w) bad++;
        end
        check("grant_blocked", 64'(bad), 64'd0);
        srv_ack  = 1'b0;
        auto_srv = 1'b1;
        wait_done(11, 100);

        // T5 reset while in REQ
        dly = 40;
        gnt_q.push_back(wd(3));
        issue(0, 1); issue(3, 1);
        k = 0;
        while (!srv_req && k < 20) begin @(negedge clk); k++; end
        check("t5_in_req", 64'(srv_req), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_srv_req", 64'(srv_req), 64'd0);
        check("t5_cli_done", 64'(cli_done), 64'd0);
        rst = 1'b0;
        dly = 2;
        push(0); push(3);
        wait_done(13, 300);

`ifdef ARB_TIMEOUT_EN
        // T6 watchdog: never ack, then a late ack is drained
        repeat (3) @(negedge clk);
        auto_srv = 1'b0;
        gnt_q.push_back(wd(2));
        e.done = 4'b0100; e.rdata = '0; e.err = 1'b1;
        done_q.push_back(e);
        issue(2, 1);
        k = 0;
        while (!srv_req && k < 20) begin @(negedge clk); k++; end
        k = 0;
        while (cli_done == '0 && k < 40) begin @(negedge clk); k++; end
        check("t6_latency", 64'(k), 64'd16);
        @(negedge clk);
        check("t6_srv_req", 64'(srv_req), 64'd0);
        srv_ack = 1'b1;
        repeat (3) @(negedge clk);
        srv_ack = 1'b0;
        repeat (12) @(negedge clk);
        check("t6_no_stray", 64'(done_cnt), 64'd14);
        auto_srv = 1'b1;
`endif

        repeat (5) @(negedge clk);
        check("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
        check("done_q_empty", 64'(done_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
